// File: rtl/vector_lane_addr_scheduler.sv
// Serialises per-lane vector element accesses onto one scalar dcache port,
// with lane masking, SEW-based byte enables/replication, load capture and misalignment trap.
module vector_lane_addr_scheduler #(
  parameter int NUM_LANES = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_load,
  input  logic                          i_store,
  input  logic [1:0]                    i_sew,
  input  logic [NUM_LANES-1:0]          i_lane_mask,
  input  logic [NUM_LANES*ADDR_W-1:0]   i_addr,
  input  logic [NUM_LANES*DATA_W-1:0]   i_storedata,
  input  logic                          i_dhit,
  input  logic [DATA_W-1:0]             i_dmemload,
  input  logic                          i_returnex,
  output logic [ADDR_W-1:0]             o_final_addr,
  output logic [DATA_W-1:0]             o_final_storedata,
  output logic [3:0]                    o_byte_ena,
  output logic                          o_ren,
  output logic                          o_wen,
  output logic [NUM_LANES-1:0]          o_arrived,
  output logic [NUM_LANES*DATA_W-1:0]   o_lane_rdata,
  output logic                          o_exception,
  output logic                          o_busy
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_EXC    = 3'd4
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [IDX_W-1:0]             r_idx;
  logic [NUM_LANES-1:0]         r_mask;
  logic [1:0]                   r_sew;
  logic                         r_op_store;

  logic [NUM_LANES*ADDR_W-1:0]  w_addr_flat;
  logic [NUM_LANES*DATA_W-1:0]  w_sdata_flat;
  logic [ADDR_W-1:0]            w_cur_addr;
  logic [DATA_W-1:0]            w_cur_data;
  logic [3:0]                   w_byte_ena;
  logic [DATA_W-1:0]            w_rep_data;
  logic                         w_cur_active;
  logic                         w_last;
  logic                         w_misalign;
  logic                         w_accept;
  logic                         w_abort;
  logic                         w_complete;
  logic                         w_capture;
  logic [NUM_LANES-1:0]         w_lane_sel;

  assign w_cur_addr   = w_addr_flat[r_idx*ADDR_W +: ADDR_W];
  assign w_cur_data   = w_sdata_flat[r_idx*DATA_W +: DATA_W];
  assign w_cur_active = r_mask[r_idx];
  assign w_last       = (r_idx == IDX_W'(NUM_LANES - 1));

  always_comb begin
    w_misalign = 1'b0;
    case (r_sew)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = w_cur_addr[0];
      2'd2:    w_misalign = |w_cur_addr[1:0];
      default: w_misalign = 1'b1;   // reserved SEW traps like a misaligned element
    endcase
  end

  always_comb begin
    w_byte_ena = 4'b1111;
    w_rep_data = w_cur_data;
    case (r_sew)
      2'd0: begin
        w_byte_ena = 4'b0001 << w_cur_addr[1:0];
        w_rep_data = {4{w_cur_data[7:0]}};
      end
      2'd1: begin
        w_byte_ena = 4'b0011 << {w_cur_addr[1], 1'b0};
        w_rep_data = {2{w_cur_data[15:0]}};
      end
      default: begin
        w_byte_ena = 4'b1111;
        w_rep_data = w_cur_data;
      end
    endcase
  end

  // A dhit coinciding with returnex is discarded: abort takes priority over completion.
  assign w_accept   = (r_state == S_IDLE) && i_start && (i_load || i_store);
  assign w_abort    = ((r_state == S_SCAN) || (r_state == S_ACCESS)) && i_returnex;
  assign w_complete = !i_returnex &&
                      (((r_state == S_SCAN) && !w_cur_active) ||
                       ((r_state == S_ACCESS) && i_dhit));
  assign w_capture  = (r_state == S_ACCESS) && i_dhit && !i_returnex && !r_op_store;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [ADDR_W-1:0] r_addr;
      logic [DATA_W-1:0] r_sdata;
      logic [DATA_W-1:0] r_rdata;
      logic              r_arrived;

      assign w_lane_sel[gi] = (r_idx == IDX_W'(gi));

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_addr    <= '0;
          r_sdata   <= '0;
          r_rdata   <= '0;
          r_arrived <= 1'b0;
        end else begin
          if (w_accept) begin
            r_addr  <= i_addr[gi*ADDR_W +: ADDR_W];
            r_sdata <= i_storedata[gi*DATA_W +: DATA_W];
          end
          if (w_capture && w_lane_sel[gi]) begin
            r_rdata <= i_dmemload;
          end
          if (w_accept || w_abort) begin
            r_arrived <= 1'b0;
          end else if (w_complete && w_lane_sel[gi]) begin
            r_arrived <= 1'b1;
          end
        end
      end

      assign w_addr_flat[gi*ADDR_W +: ADDR_W]  = r_addr;
      assign w_sdata_flat[gi*DATA_W +: DATA_W] = r_sdata;
      assign o_lane_rdata[gi*DATA_W +: DATA_W] = r_rdata;
      assign o_arrived[gi]                     = r_arrived;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx      <= '0;
      r_mask     <= '0;
      r_sew      <= '0;
      r_op_store <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx      <= '0;
        r_mask     <= i_lane_mask;
        r_sew      <= i_sew;
        r_op_store <= i_store;
      end else if (w_complete) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_SCAN;
      end
      S_SCAN: begin
        if (i_returnex)        w_state_next = S_IDLE;
        else if (!w_cur_active) w_state_next = w_last ? S_DONE : S_SCAN;
        else if (w_misalign)   w_state_next = S_EXC;
        else                   w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (i_returnex)  w_state_next = S_IDLE;
        else if (i_dhit) w_state_next = w_last ? S_DONE : S_SCAN;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      S_EXC: begin
        if (i_returnex) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_final_addr      = '0;
    o_final_storedata = '0;
    o_byte_ena        = '0;
    o_ren             = 1'b0;
    o_wen             = 1'b0;
    o_exception       = 1'b0;
    o_busy            = (r_state != S_IDLE);
    case (r_state)
      S_ACCESS: begin
        o_ren             = !r_op_store;
        o_wen             = r_op_store;
        o_final_addr      = w_cur_addr;
        o_byte_ena        = w_byte_ena;
        o_final_storedata = w_rep_data;
      end
      S_EXC: begin
        o_exception = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_vector_lane_addr_scheduler.sv
// Randomised scoreboard bench for vector_lane_addr_scheduler: a lane-level
// reference model queues expected accesses and completions; a monitor checks them.
module tb_vector_lane_addr_scheduler;
  localparam int NL = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            load = 1'b0;
  logic            store = 1'b0;
  logic [1:0]      sew = 2'd0;
  logic [NL-1:0]   mask = '0;
  logic [NL*32-1:0] addr_bus = '0;
  logic [NL*32-1:0] sdata_bus = '0;
  logic            dhit = 1'b0;
  logic [31:0]     dmemload = '0;
  logic            returnex = 1'b0;

  logic [31:0]     o_final_addr;
  logic [31:0]     o_final_storedata;
  logic [3:0]      o_byte_ena;
  logic            o_ren;
  logic            o_wen;
  logic [NL-1:0]   o_arrived;
  logic [NL*32-1:0] o_lane_rdata;
  logic            o_exception;
  logic            o_busy;

  vector_lane_addr_scheduler #(.NUM_LANES(NL), .ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_load(load), .i_store(store),
    .i_sew(sew), .i_lane_mask(mask), .i_addr(addr_bus), .i_storedata(sdata_bus),
    .i_dhit(dhit), .i_dmemload(dmemload), .i_returnex(returnex),
    .o_final_addr(o_final_addr), .o_final_storedata(o_final_storedata),
    .o_byte_ena(o_byte_ena), .o_ren(o_ren), .o_wen(o_wen), .o_arrived(o_arrived),
    .o_lane_rdata(o_lane_rdata), .o_exception(o_exception), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } acc_t;

  typedef struct {
    logic [NL-1:0]    arrived;
    logic [NL*32-1:0] rdata;
    logic             exc;
    int               cycles;
  } done_t;

  acc_t  q_acc[$];
  done_t q_done[$];
  logic [31:0] m_rdata [NL];

  int n_checks = 0;
  int n_fail = 0;

  bit resp_en = 1'b1;
  bit force_hit = 1'b0;
  int stall_max = 0;
  int wait_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // Reference model: walks lanes in order using element size in bytes.
  task automatic model_req(input bit st, input logic [1:0] s, input logic [NL-1:0] m,
                           input logic [31:0] a[NL], input logic [31:0] d[NL],
                           input int abort_lane, input bit chk_lat);
    done_t r;
    acc_t  x;
    int nacc = 0;
    int nskip = 0;
    int nb;
    bit ab = 1'b0;
    logic [31:0] elem;
    r.arrived = '0;
    r.exc = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (!m[i]) begin
        r.arrived[i] = 1'b1;
        nskip++;
        continue;
      end
      if (s == 2'd3 || (a[i] % (32'd1 << s)) != 0) begin
        r.exc = 1'b1;
        break;
      end
      nb = 1 << s;
      x.addr = a[i];
      x.we = st;
      x.be = 4'(((1 << nb) - 1) << (a[i] % 4));
      elem = (nb == 4) ? d[i] : (d[i] & ((32'd1 << (8 * nb)) - 32'd1));
      x.wdata = '0;
      for (int k = 0; k < 4 / nb; k++) x.wdata = x.wdata | (elem << (8 * nb * k));
      q_acc.push_back(x);
      nacc++;
      if (i == abort_lane) begin
        ab = 1'b1;
        break;
      end
      r.arrived[i] = 1'b1;
      if (!st) m_rdata[i] = mem_word(a[i]);
    end
    if (ab) r.arrived = '0;
    for (int i = 0; i < NL; i++) r.rdata[i*32 +: 32] = m_rdata[i];
    r.cycles = (chk_lat && !ab && !r.exc) ? (nskip + 2 * nacc + 1) : -1;
    q_done.push_back(r);
  endtask

  // Memory responder: hits after a random stall, data derived from the address.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if ((o_ren || o_wen) && (force_hit || (resp_en && wait_cnt == 0))) begin
        dhit = 1'b1;
        dmemload = mem_word(o_final_addr);
        wait_cnt = int'($urandom_range(stall_max, 0));
      end else begin
        dhit = 1'b0;
        dmemload = $urandom;
        if ((o_ren || o_wen) && resp_en && wait_cnt > 0) wait_cnt--;
      end
    end
  end

  // Monitor
  bit prev_strobe = 1'b0;
  bit prev_busy = 1'b0;
  bit prev_exc = 1'b0;
  bit prev_hit = 1'b0;
  logic [31:0] prev_addr = '0;
  int cyc = 0;
  int busy_start = 0;

  initial begin
    acc_t  x;
    done_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if ((o_ren || o_wen) && !prev_strobe) begin
        if (q_acc.size() == 0) begin
          check("unexpected_access", {32'd0, o_final_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          x = q_acc.pop_front();
          check("final_addr", {32'd0, o_final_addr}, {32'd0, x.addr});
          check("byte_ena", {60'd0, o_byte_ena}, {60'd0, x.be});
          check("ren", {63'd0, o_ren}, {63'd0, !x.we});
          check("wen", {63'd0, o_wen}, {63'd0, x.we});
          if (x.we) check("storedata", {32'd0, o_final_storedata}, {32'd0, x.wdata});
        end
      end else if ((o_ren || o_wen) && prev_strobe && !prev_hit) begin
        check("addr_stable", {32'd0, o_final_addr}, {32'd0, prev_addr});
      end
      if (o_busy && !prev_busy) busy_start = cyc;
      if ((o_exception && !prev_exc) || (!o_busy && prev_busy && !prev_exc)) begin
        if (q_done.size() == 0) begin
          check("unexpected_end", {62'd0, o_arrived}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          r = q_done.pop_front();
          check("arrived", {62'd0, o_arrived}, {62'd0, r.arrived});
          check("lane_rdata", o_lane_rdata, r.rdata);
          check("exception", {63'd0, o_exception}, {63'd0, r.exc});
          if (r.cycles >= 0) check("latency", 64'(cyc - busy_start), 64'(r.cycles));
        end
      end
      if (!o_busy && prev_busy && prev_exc) check("exc_cleared", {63'd0, o_exception}, 64'd0);
      prev_strobe = o_ren || o_wen;
      prev_busy = o_busy;
      prev_exc = o_exception;
      prev_hit = dhit;
      prev_addr = o_final_addr;
    end
  end

  task automatic issue(input bit st, input bit ld, input logic [1:0] s, input logic [NL-1:0] m,
                       input logic [31:0] a[NL], input logic [31:0] d[NL]);
    @(posedge clk);
    #1;
    store = st;
    load = ld;
    sew = s;
    mask = m;
    for (int i = 0; i < NL; i++) begin
      addr_bus[i*32 +: 32] = a[i];
      sdata_bus[i*32 +: 32] = d[i];
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    addr_bus = {$urandom, $urandom};
    sdata_bus = {$urandom, $urandom};
    sew = 2'($urandom);
    mask = NL'($urandom);
    store = 1'b0;
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (o_exception) begin
        @(posedge clk); #1; returnex = 1'b1;
        @(posedge clk); #1; returnex = 1'b0;
      end else if (!o_busy) begin
        break;
      end
    end
    if (n >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout waiting for idle: busy=%0b required 0", o_busy);
    end
    repeat (2) @(posedge clk);
    #1;
    check("acc_queue_drained", 64'(q_acc.size()), 64'd0);
    check("done_queue_drained", 64'(q_done.size()), 64'd0);
    q_acc.delete();
    q_done.delete();
  endtask

  task automatic run_req(input bit st, input bit ld, input logic [1:0] s, input logic [NL-1:0] m,
                         input logic [31:0] a[NL], input logic [31:0] d[NL], input int smax);
    stall_max = smax;
    wait_cnt = 0;
    model_req(st, s, m, a, d, -1, smax == 0);
    issue(st, ld, s, m, a, d);
    wait_idle();
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (n < 20 && !(o_ren || o_wen)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL no strobe seen: ren=%0b wen=%0b required one high", o_ren, o_wen);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a[NL];
    logic [31:0] d[NL];
    logic [31:0] base;
    bit st, ld;
    logic [1:0] s;
    int r;

    for (int i = 0; i < NL; i++) m_rdata[i] = '0;

    @(negedge clk);
    check("reset_outputs", {o_final_addr, o_final_storedata}, 64'd0);
    check("reset_ctrl", {49'd0, o_byte_ena, o_ren, o_wen, o_arrived, o_exception, o_busy, 4'd0},
          64'd0);
    check("reset_rdata", o_lane_rdata, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Word load, 1-cycle hits: DONE on the 5th busy cycle.
    a = '{32'h100, 32'h104};
    d = '{32'h0, 32'h0};
    run_req(1'b0, 1'b1, 2'd2, 2'b11, a, d, 0);

    // Byte store at 0x203.
    a = '{32'h203, 32'h208};
    d = '{32'h123456A5, 32'h0};
    run_req(1'b1, 1'b0, 2'd0, 2'b01, a, d, 2);

    // Masked lanes.
    a = '{32'h500, 32'h504};
    run_req(1'b0, 1'b1, 2'd2, 2'b10, a, d, 0);
    run_req(1'b1, 1'b0, 2'd2, 2'b00, a, d, 0);

    // Misaligned halfword on lane 1.
    a = '{32'h300, 32'h301};
    run_req(1'b0, 1'b1, 2'd1, 2'b11, a, d, 1);

    // start with neither load nor store is ignored.
    @(posedge clk); #1; start = 1'b1; load = 1'b0; store = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("no_op_start_ignored", {63'd0, o_busy}, 64'd0);

    // Stall, start-while-busy, then abort with a coincident dhit.
    resp_en = 1'b0;
    stall_max = 0;
    wait_cnt = 0;
    a = '{32'h400, 32'h404};
    model_req(1'b0, 2'd2, 2'b11, a, d, 0, 1'b0);
    issue(1'b0, 1'b1, 2'd2, 2'b11, a, d);
    wait_strobe();
    @(posedge clk); #1; start = 1'b1; load = 1'b1; addr_bus = {32'h900, 32'h904}; mask = 2'b11;
    @(posedge clk); #1; start = 1'b0; load = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1; returnex = 1'b1; force_hit = 1'b1;
    @(posedge clk); #1; returnex = 1'b0; force_hit = 1'b0; resp_en = 1'b1;
    wait_idle();

    // Next start after abort is accepted.
    a = '{32'h600, 32'h604};
    run_req(1'b0, 1'b1, 2'd2, 2'b11, a, d, 0);

    // Load+store together gives a store; async reset mid-access.
    resp_en = 1'b0;
    a = '{32'h700, 32'h704};
    d = '{32'hCAFEBABE, 32'h0};
    model_req(1'b1, 2'd2, 2'b11, a, d, 0, 1'b0);
    q_done[q_done.size()-1].rdata = '0;
    for (int i = 0; i < NL; i++) m_rdata[i] = '0;
    issue(1'b1, 1'b1, 2'd2, 2'b11, a, d);
    wait_strobe();
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    check("async_reset_data", {o_final_addr, o_final_storedata}, 64'd0);
    check("async_reset_ctrl", {49'd0, o_byte_ena, o_ren, o_wen, o_arrived, o_exception, o_busy, 4'd0},
          64'd0);
    check("async_reset_rdata", o_lane_rdata, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1; resp_en = 1'b1;
    wait_idle();

    // Randomised requests.
    for (int t = 0; t < 40; t++) begin
      st = 1'($urandom);
      ld = st ? 1'($urandom) : 1'b1;
      r = int'($urandom_range(7, 0));
      s = (r == 7) ? 2'd3 : 2'(r % 3);
      for (int i = 0; i < NL; i++) begin
        base = $urandom & 32'hFFFF_FFF0;
        if ($urandom_range(4, 0) == 0 || s == 2'd3)
          a[i] = base + 32'($urandom_range(3, 0));
        else
          a[i] = base + (32'($urandom_range(3, 0)) & ~((32'd1 << s) - 32'd1));
        d[i] = $urandom;
      end
      run_req(st, ld, s, NL'($urandom), a, d, int'($urandom_range(2, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
